ps2_capture_ctrl: RTL and testbench
===================================

# ps2_capture_ctrl

Multi-channel capture sequencer for the PS2 receive path and the output mux that follows it. It arms on a start request and steps through CHANNELS slots. In each slot it waits for a validated PS2 word, latches it into that slot, and emits a one-cycle `ready` pulse. It then waits for a release (`terminar`) before moving to the next slot or returning to idle. It is the generalised successor of the single-channel A/B/C ready controller: configurable word width, channel count and optional armed-state timeout.

## Interface
- `DATA_W`, default 8: width of one captured word.
- `CHANNELS`, default 4: number of capture slots; legal range 2..16.
- `TIMEOUT_CYC`, default 1000000: maximum cycles spent in ARMED before abort; used only with the timeout feature.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `iniciar`  in  1  start request; sampled only in IDLE.
- `valida`  in  1  PS2 word valid strobe; sampled only in ARMED.
- `terminar`  in  1  release from the consumer; sampled only in HOLD.
- `data_in`  in  DATA_W  PS2 word, qualified by `valida`.
- `ready`  out  1  registered one-cycle pulse: the word was latched into slot `chan_sel`.
- `busy`  out  1  high in ARMED or HOLD.
- `done`  out  1  registered one-cycle pulse when the last slot is released.
- `chan_sel`  out  $clog2(CHANNELS)  current slot index; drives the downstream output mux.
- `data_out`  out  CHANNELS*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W].
- `timeout_err`  out  1  registered one-cycle pulse on an armed-state timeout.

## Operation
- States are IDLE, ARMED and HOLD, encoded in 2 bits. Encoding 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - `iniciar`=1 -> ARMED, with `chan_sel` set to 0.
  - Otherwise stay in IDLE.
- ARMED:
  - `valida`=1 -> `data_out` slot[`chan_sel`] <= `data_in`, `ready` pulses, go to HOLD.
  - Otherwise stay in ARMED.
- HOLD:
  - `terminar`=1 and `chan_sel`=CHANNELS-1 -> IDLE, with `chan_sel` set to 0 and a `done` pulse.
  - `terminar`=1 and `chan_sel`<CHANNELS-1 -> ARMED, with `chan_sel`+1.
  - Otherwise stay in HOLD.
- Inputs that are not sampled in the current state are ignored:
  - `iniciar` while busy;
  - `valida` in IDLE or HOLD;
  - `terminar` in IDLE or ARMED.
- Simultaneous events:
  - In ARMED, `valida` and `terminar` both high -> only `valida` acts.
  - In HOLD, `terminar` and `valida` both high -> only `terminar` acts. A word presented in that cycle is not captured.
- Slot contents persist across runs. They are overwritten only by a new capture into the same slot or by reset.
- `chan_sel` never exceeds CHANNELS-1, and no wrap-around occurs inside a run.

## Timing
- Reset values while `rst` is high, and immediately on its assertion: state IDLE, `chan_sel`=0, `data_out`=0, `ready`=0, `done`=0, `timeout_err`=0, `busy`=0.
- Reset asserted mid-run aborts immediately. No `done` or `timeout_err` pulse is emitted.
- IDLE -> ARMED: `busy` goes high in the cycle after `iniciar` is sampled.
- Capture latency: `valida` sampled at edge N -> `data_out` slot updated and `ready`=1 from edge N, for exactly one cycle. `chan_sel` still shows the captured slot during the `ready` cycle.
- `done` follows the final `terminar` in the same way: it is high for the one cycle after edge N, and `busy` is low from that same edge.
- Best-case time to fill CHANNELS slots: 2*CHANNELS+1 cycles, counting from `iniciar`.
- `busy`, `chan_sel` and `data_out` are glitch-free register outputs.

## Configuration
- Macro `PS2_CAPTURE_TIMEOUT_EN`.
- Defined:
  - A counter of $clog2(TIMEOUT_CYC) bits clears on every entry to ARMED and increments each cycle spent in ARMED.
  - If it reaches TIMEOUT_CYC-1 with `valida`=0, the block pulses `timeout_err` for one cycle, goes to IDLE and sets `chan_sel` to 0.
  - Slots already captured are kept. The current slot is not written.
  - `valida` in the expiry cycle wins: the word is captured normally and no error is raised.
- Undefined: no counter is built, `timeout_err` is tied to 0, and ARMED waits indefinitely.

## Test plan
- Reset, then an `iniciar` pulse -> `busy`=1 and `chan_sel`=0 one cycle later; `ready`, `done` and `data_out` are all 0.
- CHANNELS=4 and DATA_W=8, with words 8'h1C, 8'h32, 8'h21, 8'h23, each followed by `terminar` -> four single-cycle `ready` pulses at `chan_sel`=0..3, then `data_out`=32'h2321321C, a `done` pulse, and a return to IDLE.
- `valida` together with `terminar` in ARMED -> capture only, state HOLD. `terminar` together with `valida` in HOLD -> advance only, slot unchanged.
- `iniciar` and `valida` pulsed while in HOLD -> no state change and no second `ready`.
- `rst` asserted in HOLD at `chan_sel`=2 -> asynchronous clear of all outputs, with no `done` pulse.
- With `PS2_CAPTURE_TIMEOUT_EN` defined and TIMEOUT_CYC=16:
  - no `valida` in ARMED -> `timeout_err` pulses after 16 cycles in ARMED, then IDLE with earlier slots intact;
  - `valida` on cycle 16 -> normal capture, no error.

Source files
------------

// File: rtl/ps2_capture_ctrl.sv
// Multi-slot PS2 capture sequencer: IDLE -> ARMED -> HOLD per slot, feeding a downstream output mux.
// Optional armed-state timeout enabled by defining PS2_CAPTURE_TIMEOUT_EN.
module ps2_capture_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iniciar,
    input  logic                         valida,
    input  logic                         terminar,
    input  logic [DATA_W-1:0]            data_in,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(CHANNELS)-1:0]  chan_sel,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         timeout_err
);

    localparam int unsigned CW = $clog2(CHANNELS);
    localparam logic [CW-1:0] LastChan = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StHold  = 2'b10
    } state_e;

    state_e                           state;
    logic [CHANNELS-1:0][DATA_W-1:0]  slot_q;

`ifdef PS2_CAPTURE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] to_cnt;
    logic          to_err_q;

    assign timeout_err = to_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_err        = 1'b0;
`endif

    assign data_out = slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            chan_sel <= '0;
            slot_q   <= '0;
            ready    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef PS2_CAPTURE_TIMEOUT_EN
            to_cnt   <= '0;
            to_err_q <= 1'b0;
`endif
        end else begin
            ready <= 1'b0;
            done  <= 1'b0;
`ifdef PS2_CAPTURE_TIMEOUT_EN
            to_err_q <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (iniciar) begin
                        state    <= StArmed;
                        busy     <= 1'b1;
                        chan_sel <= '0;
`ifdef PS2_CAPTURE_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                StArmed: begin
                    // A word arriving in the expiry cycle still wins over the timeout.
                    if (valida) begin
                        slot_q[chan_sel] <= data_in;
                        ready            <= 1'b1;
                        state            <= StHold;
                    end
`ifdef PS2_CAPTURE_TIMEOUT_EN
                    else if (to_cnt == ToLast) begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        chan_sel <= '0;
                        to_err_q <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                StHold: begin
                    if (terminar) begin
                        if (chan_sel == LastChan) begin
                            state    <= StIdle;
                            busy     <= 1'b0;
                            chan_sel <= '0;
                            done     <= 1'b1;
                        end else begin
                            state    <= StArmed;
                            chan_sel <= chan_sel + 1'b1;
`ifdef PS2_CAPTURE_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    busy     <= 1'b0;
                    chan_sel <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_capture_ctrl.sv
// Bench for ps2_capture_ctrl: directed vector table, reset/timeout sequences, random vs. slot model.
module tb_ps2_capture_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 2;

`ifdef PS2_CAPTURE_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             iniciar;
    logic             valida;
    logic             terminar;
    logic [DW-1:0]    data_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CW-1:0]    chan_sel;
    logic [CH*DW-1:0] data_out;
    logic             timeout_err;

    always #5 clk = ~clk;

    ps2_capture_ctrl #(
        .DATA_W      (DW),
        .CHANNELS    (CH),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iniciar     (iniciar),
        .valida      (valida),
        .terminar    (terminar),
        .data_in     (data_in),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .chan_sel    (chan_sel),
        .data_out    (data_out),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Slot-level model: a run is "active", either waiting for a word or for a release.
    bit               m_active, m_wait_word, m_ready, m_done, m_terr;
    int               m_ch, m_armed_cycles;
    logic [CH*DW-1:0] m_dout;

    function automatic void model_reset();
        m_active = 0; m_wait_word = 0; m_ready = 0; m_done = 0; m_terr = 0;
        m_ch = 0; m_armed_cycles = 0; m_dout = '0;
    endfunction

    function automatic void model_step(bit ini, bit val, bit term, logic [DW-1:0] d);
        m_ready = 0; m_done = 0; m_terr = 0;
        if (!m_active) begin
            if (ini) begin
                m_active = 1; m_wait_word = 1; m_ch = 0; m_armed_cycles = 0;
            end
        end else if (m_wait_word) begin
            m_armed_cycles++;
            if (val) begin
                m_dout[m_ch*DW +: DW] = d;
                m_ready = 1;
                m_wait_word = 0;
            end else if (ToEn && m_armed_cycles == TO) begin
                m_terr = 1; m_active = 0; m_ch = 0;
            end
        end else if (term) begin
            if (m_ch == CH - 1) begin
                m_done = 1; m_active = 0; m_ch = 0;
            end else begin
                m_ch++; m_wait_word = 1; m_armed_cycles = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input bit ini, input bit val, input bit term, input logic [DW-1:0] d);
        iniciar = ini; valida = val; terminar = term; data_in = d;
        @(posedge clk);
        #1;
        model_step(ini, val, term, d);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ready"},       ready,       m_ready);
        chk({tag, ".busy"},        busy,        m_active);
        chk({tag, ".done"},        done,        m_done);
        chk({tag, ".chan_sel"},    chan_sel,    m_ch);
        chk({tag, ".data_out"},    data_out,    m_dout);
        chk({tag, ".timeout_err"}, timeout_err, m_terr);
    endtask

    typedef struct {
        bit          ini, val, term;
        logic [7:0]  d;
        bit          rdy, bsy, dn;
        logic [1:0]  ch;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Full run with the simultaneous-event and ignored-input corners woven in.
        vecs[0]  = '{1, 0, 0, 8'h00, 0, 1, 0, 2'd0, 32'h0000_0000};
        vecs[1]  = '{0, 1, 0, 8'h1C, 1, 1, 0, 2'd0, 32'h0000_001C};
        vecs[2]  = '{0, 0, 1, 8'h00, 0, 1, 0, 2'd1, 32'h0000_001C};
        vecs[3]  = '{0, 1, 1, 8'h32, 1, 1, 0, 2'd1, 32'h0000_321C};
        vecs[4]  = '{0, 1, 1, 8'hFF, 0, 1, 0, 2'd2, 32'h0000_321C};
        vecs[5]  = '{0, 1, 0, 8'h21, 1, 1, 0, 2'd2, 32'h0021_321C};
        vecs[6]  = '{1, 1, 0, 8'h77, 0, 1, 0, 2'd2, 32'h0021_321C};
        vecs[7]  = '{0, 0, 1, 8'h00, 0, 1, 0, 2'd3, 32'h0021_321C};
        vecs[8]  = '{0, 1, 0, 8'h23, 1, 1, 0, 2'd3, 32'h2321_321C};
        vecs[9]  = '{0, 0, 0, 8'h00, 0, 1, 0, 2'd3, 32'h2321_321C};
        vecs[10] = '{0, 0, 1, 8'h00, 0, 0, 1, 2'd0, 32'h2321_321C};
        vecs[11] = '{0, 1, 1, 8'hAA, 0, 0, 0, 2'd0, 32'h2321_321C};

        rst = 1'b1; iniciar = 0; valida = 0; terminar = 0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.ready", ready, 0);
        chk("reset.done", done, 0);
        chk("reset.chan_sel", chan_sel, 0);
        chk("reset.data_out", data_out, 0);
        chk("reset.timeout_err", timeout_err, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].ini, vecs[i].val, vecs[i].term, vecs[i].d);
            chk($sformatf("vec%0d.ready", i), ready, vecs[i].rdy);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].bsy);
            chk($sformatf("vec%0d.done", i), done, vecs[i].dn);
            chk($sformatf("vec%0d.chan_sel", i), chan_sel, vecs[i].ch);
            chk($sformatf("vec%0d.data_out", i), data_out, vecs[i].dout);
            chk($sformatf("vec%0d.timeout_err", i), timeout_err, 0);
        end

        // Asynchronous reset while holding slot 2.
        tick(1, 0, 0, 8'h00);
        tick(0, 1, 0, 8'h11);
        tick(0, 0, 1, 8'h00);
        tick(0, 1, 0, 8'h22);
        tick(0, 0, 1, 8'h00);
        tick(0, 1, 0, 8'h33);
        tick(0, 0, 0, 8'h00);
        check_model("pre_rst");
        chk("pre_rst.chan2", chan_sel, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst.busy", busy, 0);
        chk("async_rst.chan_sel", chan_sel, 0);
        chk("async_rst.data_out", data_out, 0);
        model_reset();
        tick(0, 0, 1, 8'h00);
        chk("rst_hold.done", done, 0);
        check_model("rst_hold");
        rst = 1'b0;

`ifdef PS2_CAPTURE_TIMEOUT_EN
        // No word for 16 armed cycles on slot 1: abort, slot 0 kept.
        tick(1, 0, 0, 8'h00);
        tick(0, 1, 0, 8'h5A);
        tick(0, 0, 1, 8'h00);
        for (int i = 0; i < 15; i++) begin
            tick(0, 0, 0, 8'h00);
            chk($sformatf("to_wait%0d.err", i), timeout_err, 0);
            chk($sformatf("to_wait%0d.busy", i), busy, 1);
        end
        tick(0, 0, 0, 8'h00);
        chk("to_fire.err", timeout_err, 1);
        chk("to_fire.busy", busy, 0);
        chk("to_fire.chan_sel", chan_sel, 0);
        chk("to_fire.slot0", data_out, 32'h0000_005A);
        tick(0, 0, 0, 8'h00);
        chk("to_after.err", timeout_err, 0);
        check_model("to_after");

        // Word on the 16th armed cycle beats the timeout.
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 8'h00);
        tick(0, 1, 0, 8'h66);
        chk("to_race.ready", ready, 1);
        chk("to_race.err", timeout_err, 0);
        chk("to_race.slot0", data_out, 32'h0000_0066);
        check_model("to_race");
`endif

        rst = 1'b1;
        #3;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, DW'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
